// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;

  // States in which the loader is willing to take a stream byte.
  function automatic logic accepts_byte(input state_t s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  // Stream source / memory observer side.
  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles consecutive bytes into little-endian 32-bit words.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_c
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;
  logic [23:0]      lo_bytes;

  // Next accepted byte completes the word.
  assign last_c = (idx == IDX_W'(BYTES_PER_WORD - 1));

  // Lower bytes shift in from the top so byte 0 ends in bits [7:0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      lo_bytes   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (strobe) begin
        if (last_c) begin
          word       <= {data, lo_bytes};
          word_valid <= 1'b1;
          idx        <= '0;
        end else begin
          lo_bytes <= {data, lo_bytes[23:8]};
          idx      <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing instruction memory and gating core reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  imem_loader_if.slave  bus,
  output logic          core_reset,
  output logic          done,
  output logic          error,
  output logic [ADDR_W:0] words_loaded
);

  localparam int unsigned CAP = 1 << ADDR_W;

  state_t            state;
  logic              in_ready;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   len;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] waddr;

  logic              accept_c;
  logic              restart_ok_c;
  logic [15:0]       len_rx_c;
  logic [31:0]       pk_word;
  logic              pk_valid;
  logic              pk_last_c;

  assign accept_c     = bus.in_valid && in_ready;
  assign restart_ok_c = restart && ((state == S_DONE) || (state == S_ERROR));
  assign len_rx_c     = {bus.in_data, len_lo};

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = pk_valid;
  assign bus.imem_wdata = pk_word;
  assign bus.imem_waddr = waddr;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart_ok_c),
    .strobe     (accept_c && (state == S_DATA)),
    .data       (bus.in_data),
    .word       (pk_word),
    .word_valid (pk_valid),
    .last_c     (pk_last_c)
  );

  // Frame FSM, word counter, checksum accumulator and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_LEN_LO;
      in_ready     <= 1'b0;
      len_lo       <= '0;
      len          <= '0;
      csum         <= '0;
      waddr        <= '0;
      words_loaded <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      in_ready <= accepts_byte(state);
      if (restart_ok_c) begin
        state        <= S_LEN_LO;
        in_ready     <= 1'b1;
        csum         <= '0;
        words_loaded <= '0;
        core_reset   <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
      end else if (accept_c) begin
        case (state)
          S_LEN_LO: begin
            len_lo <= bus.in_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (32'(len_rx_c) > CAP) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else if (len_rx_c == 16'd0) begin
              state <= S_CSUM;
            end else begin
              len   <= len_rx_c[ADDR_W:0];
              state <= S_DATA;
            end
          end
          S_DATA: begin
            csum <= csum ^ bus.in_data;
            if (pk_last_c) begin
              waddr        <= words_loaded[ADDR_W-1:0];
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
              if (words_loaded + (ADDR_W+1)'(1) == len) begin
                state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned ADDR_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            restart;
  logic            core_reset;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .restart      (restart),
    .bus          (bus),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]       words[$];
  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  // Log every memory write shortly after the edge that produced it.
  always @(posedge clk) begin
    #2;
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_waddr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  // Watchdog against a stuck handshake.
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Frame = length header, little-endian payload of words[], XOR checksum ^ flip.
  task automatic make_frame(input logic [7:0] flip);
    logic [15:0] n;
    logic [7:0]  cs;
    logic [7:0]  b;
    frame.delete();
    n  = 16'(words.size());
    cs = 8'h00;
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    foreach (words[i]) begin
      for (int j = 0; j < int'(BYTES_PER_WORD); j++) begin
        b = words[i][8*j +: 8];
        frame.push_back(b);
        cs = cs ^ b;
      end
    end
    frame.push_back(cs ^ flip);
  endtask

  task automatic send_frame(input bit stall);
    foreach (frame[i]) send_byte(frame[i], stall ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
      check({tag, "_data"}, wr_data[i], words[i]);
    end
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    restart      = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_waddr", 32'(bus.imem_waddr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Nominal N=2 with write-latency checks on the first word
    words = '{32'h00100513, 32'h00200593};
    clear_log();
    make_frame(8'h00);
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    check("nom_we_w0", 32'(bus.imem_we), 32'd1);
    check("nom_waddr_w0", 32'(bus.imem_waddr), 32'd0);
    check("nom_wdata_w0", bus.imem_wdata, 32'h00100513);
    check("nom_words_w0", 32'(words_loaded), 32'd1);
    for (int i = 6; i < frame.size(); i++) begin
      send_byte(frame[i], 0);
      if (i == 6) check("nom_we_pulse", 32'(bus.imem_we), 32'd0);
    end
    check("nom_done", 32'(done), 32'd1);
    check("nom_core_reset", 32'(core_reset), 32'd0);
    check("nom_error", 32'(error), 32'd0);
    check("nom_in_ready", 32'(bus.in_ready), 32'd0);
    check("nom_words", 32'(words_loaded), 32'd2);
    check_writes("nom");
    do_restart("restart_nom");

    // Zero-length frame
    words.delete();
    clear_log();
    make_frame(8'h00);
    send_frame(1'b0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_core_reset", 32'(core_reset), 32'd0);
    @(negedge clk);
    check("zero_done_hold", 32'(done), 32'd1);
    check("zero_nwrites", 32'(wr_addr.size()), 32'd0);
    do_restart("restart_zero");

    // Bad checksum (0x31 instead of the true XOR)
    words = '{32'h00100513, 32'h00200593};
    clear_log();
    make_frame(8'h81);
    send_frame(1'b0);
    check("bad_error", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_core_reset", 32'(core_reset), 32'd1);
    check("bad_in_ready", 32'(bus.in_ready), 32'd0);
    check_writes("bad");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check("bad_sticky", 32'(error), 32'd1);
    check("bad_ready_hold", 32'(bus.in_ready), 32'd0);
    do_restart("restart_bad");

    // Oversize length N=257
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("big_error", 32'(error), 32'd1);
    check("big_in_ready", 32'(bus.in_ready), 32'd0);
    check("big_core_reset", 32'(core_reset), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    check("big_nwrites", 32'(wr_addr.size()), 32'd0);
    check("big_words", 32'(words_loaded), 32'd0);
    do_restart("restart_big");

    // Nominal frame with random valid gaps
    words = '{32'h00100513, 32'h00200593};
    clear_log();
    make_frame(8'h00);
    send_frame(1'b1);
    check("stall_done", 32'(done), 32'd1);
    check_writes("stall");
    do_restart("restart_stall");

    // Asynchronous reset after 5 payload bytes, then a fresh frame
    make_frame(8'h00);
    for (int i = 0; i < int'(LEN_BYTES) + 5; i++) send_byte(frame[i], 0);
    check("mid_words_pre", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_words", 32'(words_loaded), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_we", 32'(bus.imem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    @(negedge clk);
    send_frame(1'b0);
    check("mid_done", 32'(done), 32'd1);
    check_writes("mid");
    do_restart("restart_mid");

    // Full capacity N=2^ADDR_W
    words.delete();
    for (int k = 0; k < (1 << ADDR_W); k++) begin
      words.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    clear_log();
    make_frame(8'h00);
    send_frame(1'b0);
    check("cap_done", 32'(done), 32'd1);
    check("cap_words", 32'(words_loaded), 32'd256);
    check_writes("cap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
